writeback_stage: RTL and testbench
==================================

Name: writeback_stage

Overview:
- Final pipeline stage of the RV32 core; sits directly upstream of the register file and drives its write port (writeEn, writeSel, writeData).
- Accepts retiring instructions over a valid/ready handshake and selects the result source (ALU, load data, PC+4).
- Aligns and sign- or zero-extends load data, then buffers results in a 2-entry FIFO so register-file stalls do not drop results.
- Exposes the newest buffered result for operand forwarding to decode.

Parameters:
- SEL_W, 2, register-select width; matches the register file's writeSel width. Set to 5 for the full 32-register file.
- DEPTH, 2, result FIFO entries; fixed at 2, other values unsupported.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- inValid  in  1  upstream has an instruction to retire
- inReady  out  1  stage can accept this cycle
- inRd  in  SEL_W  destination register
- inSrc  in  2  result source: 0=ALU, 1=load, 2=PC+4, 3=no write
- inAluResult  in  32  ALU result
- inMemData  in  32  raw aligned memory word
- inFunct3  in  3  load width/sign code (RV32 encoding)
- inAddrLow  in  2  load byte offset
- inPc  in  32  instruction PC
- wbStall  in  1  register file write port unavailable this cycle
- writeEn  out  1  register file write enable
- writeSel  out  SEL_W  register file write select
- writeData  out  32  register file write data
- fwdValid  out  1  forwarding entry valid
- fwdSel  out  SEL_W  newest buffered destination
- fwdData  out  32  newest buffered data
- loadErr  out  1  one-cycle pulse: unsupported load funct3 accepted

Behaviour:
Reset:
- rst high asynchronously empties the FIFO, with count=0 and pointers=0.
- While rst is high: writeEn=0, fwdValid=0, loadErr=0, inReady=0.
- writeSel, writeData, fwdSel and fwdData read 0 while empty.
- A result accepted or in flight when reset asserts is discarded.

Handshake:
- inReady = !rst && count<2. A transfer occurs on a rising edge with inValid && inReady.
- inReady does not depend combinationally on the pop, so a full FIFO cannot accept even if it pops the same cycle.

Result formation (combinational, captured at the accept edge):
- src 0: inAluResult.
- src 2: inPc+4, mod 2^32 (0xFFFFFFFC gives 0).
- src 3: entry is pushed with a noWrite flag and still occupies a slot, preserving order.
- src 1, by funct3:
  - 000 LB: byte at inAddrLow, sign-extended.
  - 100 LBU: byte at inAddrLow, zero-extended.
  - 001 LH: halfword at inAddrLow[1], sign-extended.
  - 101 LHU: halfword at inAddrLow[1], zero-extended.
  - 010 LW: full word; inAddrLow ignored.
  - Any other funct3: data=0, entry still written, loadErr pulses for the cycle after the accept edge.
- inAddrLow[0] is ignored for halfwords; misalignment is trapped upstream.

Drain:
- Head entry is presented combinationally.
- writeEn = count>0 && !wbStall && !head.noWrite && head.rd!=0.
- The pop occurs on an edge with count>0 && !wbStall, whether or not writeEn was high. So rd=0 and noWrite entries drain silently in one cycle.
- writeSel and writeData show the head whenever count>0, independent of wbStall.

Latency:
- Accepted at edge N into an empty FIFO with wbStall low: writeEn high during cycle N..N+1; the register file commits at edge N+1.
- Throughput is one result per cycle.

Simultaneous push and pop:
- count is unchanged and ordering is strictly FIFO.
- At count 2, only a pop is possible.

Forwarding:
- fwdValid = count>0 && tail.rd!=0 && !tail.noWrite.
- fwdSel and fwdData come from the most recently pushed entry.

Pointers:
- Pointers are 1 bit each and wrap 1 to 0. count is 2 bits; pushing when full and popping when empty cannot occur by construction.

Decomposition:
- Shared package holds: the RESULT_SRC encodings (SRC_ALU, SRC_LOAD, SRC_PC4, SRC_NONE) and the LOAD_F3 constants (LB, LH, LW, LBU, LHU).
- The package also holds the FIFO entry layout, {noWrite, rd, data}.
- One natural sub-module: load_align, combinational, (funct3, addrLow, memData) -> (data, err). It is shared later by the LSU.

Test Plan:
1. Reset mid-stream: push 2 entries, wbStall=1, then pulse rst. Required: writeEn=0 and inReady=0 immediately. After release: count=0, fwdValid=0, and no write occurs.
2. ALU write: push rd=1, ALU 0xDEADBEEF with wbStall=0. Required: next cycle writeEn=1, writeSel=1, writeData=0xDEADBEEF; FIFO empty after the next edge.
3. Loads with inMemData=0x80F0_7F81:
   - LB off0 -> 0xFFFFFF81
   - LBU off0 -> 0x00000081
   - LB off1 -> 0x0000007F
   - LH off2 -> 0xFFFF80F0
   - LHU off2 -> 0x000080F0
   - LW -> 0x80F07F81
   - funct3=011 -> data 0 and one loadErr pulse
4. Backpressure: wbStall=1 and push 3 entries (0x11, 0x22, 0x33). Required: inReady falls after 2 accepts and the third is held. Release wbStall: writes 0x11, 0x22, 0x33 in order on consecutive cycles.
5. rd=0 / src=3: push rd=0 ALU 0x55, then rd=2 src=3, then rd=3 PC=0xFFFFFFFC src=2. Required: two silent pops, then writeEn for rd=3 with data 0x00000000.
6. Forwarding: wbStall=1, push rd=2 0xA then rd=3 0xB. Required: fwdSel=3, fwdData=0xB; writeSel=2 while stalled.

Source files
------------

// File: rtl/writeback_stage_pkg.sv
// Shared encodings and FIFO entry layout for the writeback stage and LSU.
package writeback_stage_pkg;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned RD_W  = 5;
    localparam int unsigned SRC_W = 2;
    localparam int unsigned F3_W  = 3;

    // Result source encodings.
    localparam logic [SRC_W-1:0] SRC_ALU  = 2'd0;
    localparam logic [SRC_W-1:0] SRC_LOAD = 2'd1;
    localparam logic [SRC_W-1:0] SRC_PC4  = 2'd2;
    localparam logic [SRC_W-1:0] SRC_NONE = 2'd3;

    // RV32 load funct3 codes.
    localparam logic [F3_W-1:0] LB  = 3'b000;
    localparam logic [F3_W-1:0] LH  = 3'b001;
    localparam logic [F3_W-1:0] LW  = 3'b010;
    localparam logic [F3_W-1:0] LBU = 3'b100;
    localparam logic [F3_W-1:0] LHU = 3'b101;

    // Result FIFO entry; rd is sized for the full register file and
    // narrower selects are zero-extended into it.
    typedef struct packed {
        logic            noWrite;
        logic [RD_W-1:0] rd;
        logic [XLEN-1:0] data;
    } wb_entry_t;

endpackage

// File: rtl/writeback_stage_load_align.sv
// Load data alignment and sign/zero extension (also reused by the LSU).
module writeback_stage_load_align
    import writeback_stage_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  addrLow,
    input  logic [31:0] memData,
    output logic [31:0] data,
    output logic        err
);

    logic [7:0]  byteVal;
    logic [15:0] halfVal;

    // Pick the addressed byte/halfword and extend according to funct3.
    always_comb begin
        byteVal = memData[7:0];
        halfVal = addrLow[1] ? memData[31:16] : memData[15:0];
        data    = 32'd0;
        err     = 1'b0;
        case (addrLow)
            2'd0:    byteVal = memData[7:0];
            2'd1:    byteVal = memData[15:8];
            2'd2:    byteVal = memData[23:16];
            default: byteVal = memData[31:24];
        endcase
        case (funct3)
            LB:      data = {{24{byteVal[7]}}, byteVal};
            LBU:     data = {24'd0, byteVal};
            LH:      data = {{16{halfVal[15]}}, halfVal};
            LHU:     data = {16'd0, halfVal};
            LW:      data = memData;
            default: err  = 1'b1;
        endcase
    end

endmodule

// File: rtl/writeback_stage.sv
// Final pipeline stage: forms results, buffers them in a 2-entry FIFO and
// drives the register file write port plus a forwarding tap.
module writeback_stage
    import writeback_stage_pkg::*;
#(
    parameter int unsigned SEL_W = 2,
    parameter int unsigned DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inValid,
    output logic             inReady,
    input  logic [SEL_W-1:0] inRd,
    input  logic [1:0]       inSrc,
    input  logic [31:0]      inAluResult,
    input  logic [31:0]      inMemData,
    input  logic [2:0]       inFunct3,
    input  logic [1:0]       inAddrLow,
    input  logic [31:0]      inPc,
    input  logic             wbStall,
    output logic             writeEn,
    output logic [SEL_W-1:0] writeSel,
    output logic [31:0]      writeData,
    output logic             fwdValid,
    output logic [SEL_W-1:0] fwdSel,
    output logic [31:0]      fwdData,
    output logic             loadErr
);

    wb_entry_t   mem [DEPTH];
    logic [1:0]  count;
    logic        wrPtr;
    logic        rdPtr;
    logic [31:0] alignData;
    logic        alignErr;
    wb_entry_t   newEntry;
    wb_entry_t   head;
    wb_entry_t   tail;
    logic        notEmpty;
    logic        push;
    logic        pop;

    writeback_stage_load_align uAlign (
        .funct3  (inFunct3),
        .addrLow (inAddrLow),
        .memData (inMemData),
        .data    (alignData),
        .err     (alignErr)
    );

    // Handshake and FIFO control; ready deliberately ignores a same-cycle pop.
    always_comb begin
        notEmpty = (count != 2'd0);
        inReady  = !rst && (count < 2'(DEPTH));
        push     = inValid && inReady;
        pop      = notEmpty && !wbStall;
        head     = mem[rdPtr];
        tail     = mem[~wrPtr];
    end

    // Result formation from the selected source.
    always_comb begin
        newEntry.noWrite = 1'b0;
        newEntry.rd      = RD_W'(inRd);
        newEntry.data    = inAluResult;
        case (inSrc)
            SRC_LOAD: newEntry.data = alignData;
            SRC_PC4:  newEntry.data = inPc + 32'd4;
            SRC_NONE: newEntry.noWrite = 1'b1;
            default:  newEntry.data = inAluResult;
        endcase
    end

    // Register file port from the head, forwarding tap from the tail.
    always_comb begin
        writeEn   = pop && !head.noWrite && (head.rd != '0);
        writeSel  = notEmpty ? head.rd[SEL_W-1:0] : '0;
        writeData = notEmpty ? head.data : 32'd0;
        fwdValid  = notEmpty && !tail.noWrite && (tail.rd != '0);
        fwdSel    = notEmpty ? tail.rd[SEL_W-1:0] : '0;
        fwdData   = notEmpty ? tail.data : 32'd0;
    end

    // FIFO storage, pointers, occupancy and the load error pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count   <= 2'd0;
            wrPtr   <= 1'b0;
            rdPtr   <= 1'b0;
            loadErr <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            loadErr <= push && (inSrc == SRC_LOAD) && alignErr;
            if (push) begin
                mem[wrPtr] <= newEntry;
                wrPtr      <= ~wrPtr;
            end
            if (pop) begin
                rdPtr <= ~rdPtr;
            end
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_writeback_stage.sv
// Self-checking bench for writeback_stage: vector table, scoreboard of
// register-file writes, and hand-written multi-cycle sequences.
module tb_writeback_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        inValid;
    logic        inReady;
    logic [1:0]  inRd;
    logic [1:0]  inSrc;
    logic [31:0] inAluResult;
    logic [31:0] inMemData;
    logic [2:0]  inFunct3;
    logic [1:0]  inAddrLow;
    logic [31:0] inPc;
    logic        wbStall;
    logic        writeEn;
    logic [1:0]  writeSel;
    logic [31:0] writeData;
    logic        fwdValid;
    logic [1:0]  fwdSel;
    logic [31:0] fwdData;
    logic        loadErr;

    int nTests = 0;
    int nFails = 0;

    typedef struct {
        logic [1:0]  sel;
        logic [31:0] data;
    } wr_t;
    wr_t expQ[$];

    typedef struct {
        logic [1:0]  rd;
        logic [1:0]  src;
        logic [2:0]  f3;
        logic [1:0]  addr;
        logic [31:0] mem;
        logic [31:0] alu;
        logic [31:0] pc;
        logic [31:0] expData;
        logic        expErr;
    } vec_t;
    vec_t vecs[$];

    writeback_stage #(.SEL_W(2), .DEPTH(2)) dut (
        .clk         (clk),
        .rst         (rst),
        .inValid     (inValid),
        .inReady     (inReady),
        .inRd        (inRd),
        .inSrc       (inSrc),
        .inAluResult (inAluResult),
        .inMemData   (inMemData),
        .inFunct3    (inFunct3),
        .inAddrLow   (inAddrLow),
        .inPc        (inPc),
        .wbStall     (wbStall),
        .writeEn     (writeEn),
        .writeSel    (writeSel),
        .writeData   (writeData),
        .fwdValid    (fwdValid),
        .fwdSel      (fwdSel),
        .fwdData     (fwdData),
        .loadErr     (loadErr)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nTests++;
        if (act !== exp) begin
            nFails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Scoreboard: every register-file write must match the oldest expectation.
    always @(negedge clk) begin
        if (writeEn === 1'b1) begin
            nTests++;
            if (expQ.size() == 0) begin
                nFails++;
                $display("FAIL unexpected_write: got sel=%0d data=0x%08h expected no write", writeSel, writeData);
            end else begin
                wr_t e;
                e = expQ.pop_front();
                if (writeSel !== e.sel || writeData !== e.data) begin
                    nFails++;
                    $display("FAIL sb_write: got sel=%0d data=0x%08h expected sel=%0d data=0x%08h",
                             writeSel, writeData, e.sel, e.data);
                end
            end
        end
    end

    // Advance to just after the next rising edge.
    task automatic sync();
        @(posedge clk);
        #1;
    endtask

    // Present one instruction and hold it until accepted (bounded).
    task automatic pushOne(input logic [1:0] rd, input logic [1:0] src, input logic [2:0] f3,
                           input logic [1:0] addr, input logic [31:0] memW,
                           input logic [31:0] alu, input logic [31:0] pc);
        logic ready;
        bit   done;
        done        = 1'b0;
        inRd        = rd;
        inSrc       = src;
        inFunct3    = f3;
        inAddrLow   = addr;
        inMemData   = memW;
        inAluResult = alu;
        inPc        = pc;
        inValid     = 1'b1;
        for (int c = 0; c < 20 && !done; c++) begin
            #1;
            ready = inReady;
            @(posedge clk);
            #1;
            if (ready) done = 1'b1;
        end
        inValid = 1'b0;
        nTests++;
        if (!done) begin
            nFails++;
            $display("FAIL accept_timeout: got no accept expected accept within 20 cycles");
        end
    endtask

    task automatic expectWrite(input logic [1:0] sel, input logic [31:0] data);
        wr_t e;
        e.sel  = sel;
        e.data = data;
        expQ.push_back(e);
    endtask

    function automatic vec_t mkVec(input logic [1:0] rd, input logic [1:0] src, input logic [2:0] f3,
                                   input logic [1:0] addr, input logic [31:0] memW, input logic [31:0] alu,
                                   input logic [31:0] pc, input logic [31:0] expData, input logic expErr);
        vec_t v;
        v.rd = rd; v.src = src; v.f3 = f3; v.addr = addr; v.mem = memW;
        v.alu = alu; v.pc = pc; v.expData = expData; v.expErr = expErr;
        return v;
    endfunction

    initial begin
        rst = 1'b1; inValid = 1'b0; inRd = '0; inSrc = '0; inAluResult = '0;
        inMemData = '0; inFunct3 = '0; inAddrLow = '0; inPc = '0; wbStall = 1'b0;

        vecs.push_back(mkVec(2'd1, 2'd1, 3'b000, 2'd0, 32'h80F07F81, 32'h0, 32'h0, 32'hFFFFFF81, 1'b0));
        vecs.push_back(mkVec(2'd2, 2'd1, 3'b100, 2'd0, 32'h80F07F81, 32'h0, 32'h0, 32'h00000081, 1'b0));
        vecs.push_back(mkVec(2'd3, 2'd1, 3'b000, 2'd1, 32'h80F07F81, 32'h0, 32'h0, 32'h0000007F, 1'b0));
        vecs.push_back(mkVec(2'd1, 2'd1, 3'b001, 2'd2, 32'h80F07F81, 32'h0, 32'h0, 32'hFFFF80F0, 1'b0));
        vecs.push_back(mkVec(2'd2, 2'd1, 3'b101, 2'd2, 32'h80F07F81, 32'h0, 32'h0, 32'h000080F0, 1'b0));
        vecs.push_back(mkVec(2'd3, 2'd1, 3'b010, 2'd3, 32'h80F07F81, 32'h0, 32'h0, 32'h80F07F81, 1'b0));
        vecs.push_back(mkVec(2'd1, 2'd1, 3'b011, 2'd0, 32'h80F07F81, 32'h0, 32'h0, 32'h00000000, 1'b1));
        vecs.push_back(mkVec(2'd2, 2'd1, 3'b000, 2'd3, 32'h80F07F81, 32'h0, 32'h0, 32'hFFFFFF80, 1'b0));
        vecs.push_back(mkVec(2'd3, 2'd2, 3'b000, 2'd0, 32'h0, 32'h0, 32'h00000100, 32'h00000104, 1'b0));
        vecs.push_back(mkVec(2'd1, 2'd0, 3'b011, 2'd0, 32'h0, 32'h12345678, 32'h0, 32'h12345678, 1'b0));

        // Reset state.
        #2;
        check("rst_inReady", inReady, 0);
        check("rst_writeEn", writeEn, 0);
        check("rst_fwdValid", fwdValid, 0);
        check("rst_loadErr", loadErr, 0);
        check("rst_writeSel", writeSel, 0);
        check("rst_writeData", writeData, 0);
        sync();
        sync();
        rst = 1'b0;
        sync();

        // Reset mid-stream discards buffered results.
        wbStall = 1'b1;
        pushOne(2'd1, 2'd0, 3'b0, 2'd0, 32'h0, 32'h00000AAA, 32'h0);
        pushOne(2'd2, 2'd0, 3'b0, 2'd0, 32'h0, 32'h00000BBB, 32'h0);
        check("pre_rst_fwdValid", fwdValid, 1);
        check("pre_rst_inReady", inReady, 0);
        #2;
        rst = 1'b1;
        #1;
        check("midrst_writeEn", writeEn, 0);
        check("midrst_inReady", inReady, 0);
        check("midrst_fwdValid", fwdValid, 0);
        sync();
        sync();
        rst = 1'b0;
        wbStall = 1'b0;
        #1;
        check("postrst_inReady", inReady, 1);
        check("postrst_fwdValid", fwdValid, 0);
        check("postrst_writeSel", writeSel, 0);
        repeat (3) sync();

        // Single ALU write latency and drain.
        expectWrite(2'd1, 32'hDEADBEEF);
        pushOne(2'd1, 2'd0, 3'b0, 2'd0, 32'h0, 32'hDEADBEEF, 32'h0);
        check("alu_writeEn", writeEn, 1);
        check("alu_writeSel", writeSel, 1);
        check("alu_writeData", writeData, 32'hDEADBEEF);
        sync();
        check("alu_drained_writeEn", writeEn, 0);
        check("alu_drained_fwdValid", fwdValid, 0);

        // Vector table: result formation and load error pulse.
        foreach (vecs[i]) begin
            expectWrite(vecs[i].rd, vecs[i].expData);
            pushOne(vecs[i].rd, vecs[i].src, vecs[i].f3, vecs[i].addr, vecs[i].mem, vecs[i].alu, vecs[i].pc);
            @(negedge clk);
            check($sformatf("vec%0d_loadErr", i), loadErr, 32'(vecs[i].expErr));
            check($sformatf("vec%0d_writeEn", i), writeEn, 1);
            check($sformatf("vec%0d_writeData", i), writeData, vecs[i].expData);
            sync();
        end

        // Backpressure: two accepts, third held, then in-order drain.
        wbStall = 1'b1;
        expectWrite(2'd1, 32'h11);
        expectWrite(2'd2, 32'h22);
        expectWrite(2'd3, 32'h33);
        pushOne(2'd1, 2'd0, 3'b0, 2'd0, 32'h0, 32'h11, 32'h0);
        pushOne(2'd2, 2'd0, 3'b0, 2'd0, 32'h0, 32'h22, 32'h0);
        inRd = 2'd3; inSrc = 2'd0; inAluResult = 32'h33; inValid = 1'b1;
        #1;
        check("bp_full_inReady", inReady, 0);
        sync();
        check("bp_held_inReady", inReady, 0);
        check("bp_held_writeEn", writeEn, 0);
        check("bp_held_writeSel", writeSel, 1);
        wbStall = 1'b0;
        #1;
        check("bp_d0_writeEn", writeEn, 1);
        check("bp_d0_writeData", writeData, 32'h11);
        check("bp_d0_inReady", inReady, 0);
        sync();
        check("bp_d1_writeEn", writeEn, 1);
        check("bp_d1_writeData", writeData, 32'h22);
        check("bp_d1_inReady", inReady, 1);
        sync();
        inValid = 1'b0;
        check("bp_d2_writeEn", writeEn, 1);
        check("bp_d2_writeData", writeData, 32'h33);
        sync();
        check("bp_done_writeEn", writeEn, 0);

        // Silent pops for rd=0 and no-write entries, then PC+4 wrap.
        pushOne(2'd0, 2'd0, 3'b0, 2'd0, 32'h0, 32'h55, 32'h0);
        #1;
        check("rd0_writeEn", writeEn, 0);
        check("rd0_fwdValid", fwdValid, 0);
        pushOne(2'd2, 2'd3, 3'b0, 2'd0, 32'h0, 32'h77, 32'h0);
        #1;
        check("nowr_writeEn", writeEn, 0);
        check("nowr_fwdValid", fwdValid, 0);
        expectWrite(2'd3, 32'h00000000);
        pushOne(2'd3, 2'd2, 3'b0, 2'd0, 32'h0, 32'h0, 32'hFFFFFFFC);
        #1;
        check("pc4_writeEn", writeEn, 1);
        check("pc4_writeSel", writeSel, 3);
        check("pc4_writeData", writeData, 32'h0);
        sync();

        // Forwarding shows the newest entry while the head is stalled.
        wbStall = 1'b1;
        expectWrite(2'd2, 32'hA);
        expectWrite(2'd3, 32'hB);
        pushOne(2'd2, 2'd0, 3'b0, 2'd0, 32'h0, 32'hA, 32'h0);
        #1;
        check("fwd1_fwdSel", fwdSel, 2);
        check("fwd1_fwdData", fwdData, 32'hA);
        pushOne(2'd3, 2'd0, 3'b0, 2'd0, 32'h0, 32'hB, 32'h0);
        #1;
        check("fwd_fwdValid", fwdValid, 1);
        check("fwd_fwdSel", fwdSel, 3);
        check("fwd_fwdData", fwdData, 32'hB);
        check("fwd_writeSel", writeSel, 2);
        check("fwd_writeData", writeData, 32'hA);
        check("fwd_writeEn", writeEn, 0);
        wbStall = 1'b0;

        // Drain remaining expectations (bounded).
        for (int c = 0; c < 20 && expQ.size() != 0; c++) sync();
        check("sb_empty", 32'(expQ.size()), 0);
        sync();

        $display("[TB] %0d tests run, %0d failed", nTests, nFails);
        $finish;
    end

endmodule
